// File: rtl/intc_vec.sv
// Vectored interrupt controller: edge-detected pending bits, software mask, fixed priority
// (channel 0 highest), and an irq/EAddr handshake with the core via iack.
module intc_vec #(
  parameter int unsigned N_CH    = 8,
  parameter logic [31:0] VEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] done,
  input  logic [1:0]      A,
  input  logic            WE,
  input  logic [31:0]     WD,
  output logic [31:0]     RD,
  output logic            irq,
  output logic [31:0]     EAddr,
  input  logic            iack
);

  typedef enum logic [1:0] {StIdle, StAssert, StWaitRel} state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   done_q;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [31:0]       vbase_q, vbase_d;
  logic [4:0]        id_q, id_d;
  logic [31:0]       eaddr_q, eaddr_d;

  logic [N_CH-1:0]   set_pulse, w1c, ack_clr, req;
  logic [4:0]        win;
  logic              wr_pend, wr_mask, wr_vbase;
  logic              unused_wd;

  assign unused_wd = ^WD[1:0];

  assign wr_pend  = WE && (A == 2'd0);
  assign wr_mask  = WE && (A == 2'd1);
  assign wr_vbase = WE && (A == 2'd3);

  assign set_pulse = done & ~done_q;
  assign w1c       = wr_pend ? WD[N_CH-1:0] : '0;
  assign req       = pend_q & mask_q;

  // Lowest index wins: scan downwards so the last assignment is the smallest set bit.
  always_comb begin
    win = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) win = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    eaddr_d = eaddr_q;
    ack_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          id_d    = win;
          eaddr_d = vbase_q + {25'b0, win, 2'b00};
          state_d = StAssert;
        end
      end
      StAssert: begin
        if (iack) begin
          for (int i = 0; i < N_CH; i++) begin
            ack_clr[i] = (id_q == 5'(i));
          end
          state_d = StWaitRel;
        end
      end
      StWaitRel: begin
        if (!iack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A set pulse overrides any clear arriving in the same cycle.
  assign pend_d  = set_pulse | (pend_q & ~(w1c | ack_clr));
  assign mask_d  = wr_mask ? WD[N_CH-1:0] : mask_q;
  assign vbase_d = wr_vbase ? {WD[31:2], 2'b00} : vbase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      vbase_q <= {VEC_RST[31:2], 2'b00};
      id_q    <= '0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vbase_q <= vbase_d;
      id_q    <= id_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign irq   = (state_q == StAssert);
  assign EAddr = eaddr_q;

  always_comb begin
    RD = '0;
    unique case (A)
      2'd0: RD[N_CH-1:0] = pend_q;
      2'd1: RD[N_CH-1:0] = mask_q;
      2'd2: RD = {(state_q != StIdle), 26'b0, id_q};
      2'd3: RD = vbase_q;
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_vec.sv
// Bench for intc_vec: directed walkthrough of the register map and handshake, then random
// traffic checked every cycle against a behavioural model.
module tb_intc_vec;

  localparam int unsigned NCh = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  done;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        irq;
  logic [31:0] EAddr;
  logic        iack;

  int n_checks = 0;
  int n_fail   = 0;

  intc_vec #(
    .N_CH   (NCh),
    .VEC_RST(32'h0000_0100)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .done (done),
    .A    (A),
    .WE   (WE),
    .WD   (WD),
    .RD   (RD),
    .irq  (irq),
    .EAddr(EAddr),
    .iack (iack)
  );

  always #5 clk = ~clk;

  // Behavioural model; phase 0 = idle, 1 = irq raised, 2 = waiting for iack release.
  logic [7:0]  m_pend, m_mask, m_done_q;
  logic [31:0] m_vbase, m_eaddr;
  int          m_phase, m_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'hFF; m_done_q = 8'h00;
    m_vbase = 32'h100; m_eaddr = 32'h0; m_phase = 0; m_id = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_pend};
      2'd1:    return {24'b0, m_mask};
      2'd2:    return {(m_phase != 0), 26'b0, 5'(m_id)};
      default: return m_vbase;
    endcase
  endfunction

  task automatic model_edge();
    logic [7:0] setp, clr, req;
    int win;
    setp = done & ~m_done_q;
    clr  = (WE && A == 2'd0) ? WD[7:0] : 8'h00;
    req  = m_pend & m_mask;
    win  = -1;
    for (int i = 0; i < NCh; i++) if (req[i] && win < 0) win = i;
    case (m_phase)
      0: if (win >= 0) begin
        m_id = win; m_eaddr = m_vbase + 32'(4 * win); m_phase = 1;
      end
      1: if (iack) begin
        clr[m_id] = 1'b1; m_phase = 2;
      end
      default: if (!iack) m_phase = 0;
    endcase
    m_pend = setp | (m_pend & ~clr);
    if (WE && A == 2'd1) m_mask = WD[7:0];
    if (WE && A == 2'd3) m_vbase = {WD[31:2], 2'b00};
    m_done_q = done;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", 32'(irq), 32'(m_phase == 1));
    check("eaddr", EAddr, m_eaddr);
    check("rd", RD, m_rd(A));
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp);
    A = a;
    #1;
    check($sformatf("rd_a%0d", a), RD, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE = 1'b1; A = a; WD = d;
    step();
    WE = 1'b0; WD = '0;
  endtask

  task automatic ack();
    iack = 1'b1;
    step();
    check("irq_after_iack", 32'(irq), 32'd0);
    iack = 1'b0;
    step();
  endtask

  int grants;
  logic last_irq;

  initial begin
    rst = 1'b1; done = '0; A = '0; WE = 1'b0; WD = '0; iack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();

    // Reset values and VBASE low-bit masking.
    peek(2'd0, 32'h0); peek(2'd1, 32'hFF); peek(2'd2, 32'h0); peek(2'd3, 32'h100);
    wr(2'd3, 32'h203);
    peek(2'd3, 32'h200);
    wr(2'd3, 32'h100);

    // Single channel with two-cycle latency.
    done = 8'h08; step();
    check("ch3_latency", 32'(irq), 32'd0);
    done = 8'h00; step();
    check("ch3_irq", 32'(irq), 32'd1);
    check("ch3_eaddr", EAddr, 32'h10C);
    peek(2'd2, 32'h8000_0003);
    iack = 1'b1; step();
    check("ch3_drop", 32'(irq), 32'd0);
    peek(2'd0, 32'h0);
    iack = 1'b0; step();
    peek(2'd2, 32'h3);

    // Masked ch2 waits behind ch5, then wins after unmask.
    wr(2'd1, 32'hFB);
    done = 8'h24; step();
    done = 8'h00; step();
    check("ch5_eaddr", EAddr, 32'h114);
    wr(2'd1, 32'hFF);
    check("ch5_frozen", EAddr, 32'h114);
    ack();
    step();
    check("ch2_irq", 32'(irq), 32'd1);
    check("ch2_eaddr", EAddr, 32'h108);
    ack();

    // New edge coincides with the iack that clears the same channel.
    done = 8'h04; step();
    done = 8'h00; step();
    check("ch2b_irq", 32'(irq), 32'd1);
    done = 8'h04; iack = 1'b1; step();
    peek(2'd0, 32'h04);
    done = 8'h00; iack = 1'b0; step();
    step();
    check("ch2_regrant", 32'(irq), 32'd1);
    ack();

    // W1C coinciding with a set edge leaves the bit set.
    WE = 1'b1; A = 2'd0; WD = 32'h04; done = 8'h04; step();
    WE = 1'b0; WD = '0; done = 8'h00;
    peek(2'd0, 32'h04);
    step();
    ack();

    // W1C of the granted bit during ASSERT keeps irq high.
    done = 8'h02; step();
    done = 8'h00; step();
    wr(2'd0, 32'h02);
    check("w1c_keeps_irq", 32'(irq), 32'd1);
    peek(2'd0, 32'h0);
    ack();

    // Held level gives exactly one grant.
    grants = 0; last_irq = 1'b0;
    done = 8'h01;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq && !last_irq) grants++;
      last_irq = irq;
      iack = irq;
    end
    check("held_grants", 32'(grants), 32'd1);
    done = 8'h00; iack = 1'b0; step(); step();

    // Asynchronous reset in ASSERT; done held across release.
    done = 8'h10; step();
    done = 8'h00; step();
    check("pre_rst_irq", 32'(irq), 32'd1);
    #2 rst = 1'b1; done = 8'h02;
    #1;
    model_reset();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_eaddr", EAddr, 32'h0);
    peek(2'd0, 32'h0); peek(2'd1, 32'hFF); peek(2'd2, 32'h0); peek(2'd3, 32'h100);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("post_rst_eaddr", EAddr, 32'h104);
    ack();
    done = 8'h00; step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      done = done ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      A    = 2'($urandom_range(0, 3));
      WE   = ($urandom_range(0, 5) == 0);
      WD   = $urandom;
      if (WE && A == 2'd1 && $urandom_range(0, 1) == 1) WD[7:0] = 8'hFF;
      if (irq) iack = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 2) != 0) iack = 1'b0;
      else iack = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intc_vec.md
# intc_vec

Parametrised vectored interrupt controller: the next generation of the system's four-input interrupt controller. It edge-detects `N_CH` peripheral done/event lines and latches them into pending bits. It applies a software mask and fixed priority, then drives `irq`/`EAddr` to the MIPS core with an `iack` handshake. It is memory-mapped behind the address decoder like the fact and GPIO blocks, with its read data feeding the read-data mux.

## Interface
- `N_CH`, 8: number of interrupt channels, 1..16.
- `VEC_RST`, 32'h0000_0100: reset value of the vector base register; bits [1:0] must be 0.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `done  in  N_CH`: event lines from peripherals; level signals, rising edge raises a request.
- `A  in  2`: register word select, driven from the word-address bits of the ALU output.
- `WE  in  1`: register write enable, from the address decoder.
- `WD  in  32`: write data.
- `RD  out  32`: read data, combinational from `A`.
- `irq  out  1`: interrupt request to the core.
- `EAddr  out  32`: handler address, valid while `irq`=1.
- `iack  in  1`: acknowledge from the core, level.

## Operation
- Register map (`A`):
  - 0 PEND: read returns pending bits, zero-extended. Write is write-1-to-clear.
  - 1 MASK: read/write, bit i=1 enables channel i.
  - 2 STAT: read-only, {active, 26'b0, id[4:0]}. `active`=1 in ASSERT or WAITREL. `id` is the last granted channel.
  - 3 VBASE: read/write. `WD[1:0]` is ignored and stored as 0.
- Bits at or above `N_CH` read 0 and ignore writes.
- Reset values: PEND=0, MASK=all ones over `N_CH` bits, VBASE=`VEC_RST`, id=0, state IDLE, `irq`=0, `EAddr`=0, edge-detect register=0.
- Edge detect: the `done_q` register samples `done` every cycle. A channel's set pulse is `done & ~done_q`. A line held high raises one request only.
- Pending update per bit, per cycle: set pulse wins over both W1C and iack-clear in the same cycle; otherwise either clear source clears the bit.
- Grant: the lowest-index channel with PEND&MASK set wins. Channel 0 has highest priority.
- State machine:
  - IDLE: if any PEND&MASK bit is set, latch `id` = winner and `EAddr` = VBASE + 4·winner; go to ASSERT.
  - ASSERT: `irq`=1. `id`/`EAddr` are frozen, even if MASK or PEND change. When `iack`=1, clear PEND[id] (subject to the set-wins rule), drop `irq`, go to WAITREL.
  - WAITREL: `irq`=0. Stay until `iack`=0, then go to IDLE.
- EAddr arithmetic is 32-bit with wrap-around modulo 2^32. It holds its last value outside ASSERT.
- A grant stays committed: clearing its PEND bit by W1C while in ASSERT does not drop `irq`.
- A write to MASK or VBASE affects only the next grant.
- Reset asserted mid-operation, in any state, returns everything to reset values immediately, with `irq`=0 asynchronously.

## Timing
- `done` rises before edge t0 → PEND bit set after t0 → ASSERT with `irq`=1 and `EAddr` valid after t1. Latency is 2 cycles.
- `iack` high before edge tk → `irq`=0 after tk.
- `iack` low before edge tm → IDLE after tm. The earliest next `irq` is after tm+1. The minimum gap between two grants is therefore 2 cycles after `iack` falls.
- Register writes take effect at the clock edge. RD reflects the new value in the following cycle.
- `iack` is ignored in IDLE. An `iack` already high on entry to ASSERT is accepted at the next edge.

## Test plan
- Reset and map: after reset, read A=0..3 → 0, 0xFF, 0, 0x100 (`N_CH`=8). Write VBASE=0x203 → reads back 0x200.
- Single channel: pulse `done[3]` → `irq`=1 two cycles later, `EAddr`=0x10C, STAT=0x8000_0003. Raise `iack` → `irq` drops next cycle, PEND=0. Lower `iack` → IDLE.
- Priority and masking: raise `done[5]` and `done[2]` together with MASK=0xFB → grant ch5, `EAddr`=0x114. Then set MASK=0xFF → after the ch5 handshake, grant ch2, `EAddr`=0x108.
- Simultaneous events: a new `done[2]` edge in the same cycle as the `iack` that clears ch2 → PEND[2] stays 1 and a second grant of ch2 follows. W1C of PEND=0x04 coinciding with a set edge → bit stays 1.
- Held level / W1C: hold `done[0]` high for 20 cycles → exactly one grant. Write PEND=0x01 during ASSERT → `irq` stays 1 until `iack`.
- Reset mid-operation: assert `rst` in ASSERT → `irq`=0 immediately, all registers at reset values. A `done` held high across reset release raises a request on its first sampled edge after reset.
